// File: rtl/decode_execute_reg.sv
// decode_execute_reg
//   Decode-to-execute pipeline register with a per-register write scoreboard.
//   Captures register-file read data and control from decode, hands them to
//   execute over a valid/ready handshake, counts in-flight writes per
//   architectural register and stalls decode on read-after-write hazards or
//   when a destination's counter is saturated. A flush squashes the slot.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   idValid                    decode presents an instruction
//   rSel1, rSel2, useOp1/2     source identifiers and their use flags
//   regWrEn, regToWrite        destination write enable and identifier
//   aluCtrl, operand1/2        control field and operand data to capture
//   exReady                    execute consumes the slot this cycle
//   flush                      squash decode and the execute-side slot
//   wbValid, wbReg             writeback retires a register write
//   stall                      decode must hold (combinational)
//   exValid, exOperand1/2,
//   exAluCtrl, exRegWrEn,
//   exRegToWrite               execute-side slot contents
//   scbErr                     sticky: retire seen with zero pending writes

module decode_execute_reg #(
    parameter int registerSize  = 8,
    parameter int vecSize       = 16,
    parameter int selectionBits = 3,
    parameter int ctrlBits      = 6
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            idValid,
    input  logic [selectionBits-1:0]        rSel1,
    input  logic [selectionBits-1:0]        rSel2,
    input  logic                            useOp1,
    input  logic                            useOp2,
    input  logic                            regWrEn,
    input  logic [selectionBits-1:0]        regToWrite,
    input  logic [ctrlBits-1:0]             aluCtrl,
    input  logic [vecSize*registerSize-1:0] operand1,
    input  logic [vecSize*registerSize-1:0] operand2,
    input  logic                            exReady,
    input  logic                            flush,
    input  logic                            wbValid,
    input  logic [selectionBits-1:0]        wbReg,
    output logic                            stall,
    output logic                            exValid,
    output logic [vecSize*registerSize-1:0] exOperand1,
    output logic [vecSize*registerSize-1:0] exOperand2,
    output logic [ctrlBits-1:0]             exAluCtrl,
    output logic                            exRegWrEn,
    output logic [selectionBits-1:0]        exRegToWrite,
    output logic                            scbErr
);

    localparam int NUM_REGS = 2 ** selectionBits;

    logic [1:0]          pending     [NUM_REGS];
    logic [1:0]          pending_nxt [NUM_REGS];
    logic [2:0]          up_cnt      [NUM_REGS];
    logic [2:0]          down_cnt    [NUM_REGS];
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] dec_wb;
    logic [NUM_REGS-1:0] dec_fl;
    logic                hazard;
    logic                accept;
    logic                wb_err;

    // Source checks use the registered counters: a retire in cycle N only
    // releases a dependent decode in cycle N+1, when the register file has
    // the written data (no forwarding path exists).
    always_comb begin
        hazard = idValid && ((useOp1 && (pending[rSel1] != 2'd0)) ||
                             (useOp2 && (pending[rSel2] != 2'd0)) ||
                             (regWrEn && (pending[regToWrite] == 2'd3)));
        accept = idValid && !hazard && !flush && (!exValid || exReady);
        wb_err = wbValid && (pending[wbReg] == 2'd0);
    end

    // A flushed decode instruction is discarded, so it is not reported as stalled.
    assign stall = idValid && !accept && !flush;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            inc[r]    = accept && regWrEn && (regToWrite == selectionBits'(r));
            dec_wb[r] = wbValid && (wbReg == selectionBits'(r)) && (pending[r] != 2'd0);
            // Undo the increment of a squashed slot; if execute takes it in
            // the same cycle the write is really in flight and must stay counted.
            dec_fl[r] = flush && exValid && !exReady && exRegWrEn &&
                        (exRegToWrite == selectionBits'(r));
            up_cnt[r]   = {1'b0, pending[r]} + {2'b00, inc[r]};
            down_cnt[r] = {2'b00, dec_wb[r]} + {2'b00, dec_fl[r]};
            if (up_cnt[r] <= down_cnt[r]) begin
                pending_nxt[r] = 2'd0;
            end else if ((up_cnt[r] - down_cnt[r]) > 3'd3) begin
                pending_nxt[r] = 2'd3;
            end else begin
                pending_nxt[r] = 2'(up_cnt[r] - down_cnt[r]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pending[r] <= 2'd0;
            end
            scbErr <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pending[r] <= pending_nxt[r];
            end
            if (wb_err) begin
                scbErr <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exValid      <= 1'b0;
            exOperand1   <= '0;
            exOperand2   <= '0;
            exAluCtrl    <= '0;
            exRegWrEn    <= 1'b0;
            exRegToWrite <= '0;
        end else if (flush) begin
            exValid <= 1'b0;
        end else if (accept) begin
            exValid      <= 1'b1;
            exOperand1   <= operand1;
            exOperand2   <= operand2;
            exAluCtrl    <= aluCtrl;
            exRegWrEn    <= regWrEn;
            exRegToWrite <= regToWrite;
        end else if (exReady) begin
            exValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_execute_reg.sv
// tb_decode_execute_reg
//   Directed table of per-cycle vectors for decode_execute_reg with
//   hand-computed expectations, followed by a mid-operation reset sequence.
//   Operand data is derived from a per-vector seed: lane i = seed + i for
//   operand1 and seed + 128 + i for operand2.

module tb_decode_execute_reg;

    localparam int RS  = 8;
    localparam int VS  = 16;
    localparam int SB  = 3;
    localparam int CB  = 6;
    localparam int OPW = RS * VS;

    logic           clk = 1'b0;
    logic           reset;
    logic           idValid;
    logic [SB-1:0]  rSel1, rSel2;
    logic           useOp1, useOp2;
    logic           regWrEn;
    logic [SB-1:0]  regToWrite;
    logic [CB-1:0]  aluCtrl;
    logic [OPW-1:0] operand1, operand2;
    logic           exReady;
    logic           flush;
    logic           wbValid;
    logic [SB-1:0]  wbReg;
    logic           stall;
    logic           exValid;
    logic [OPW-1:0] exOperand1, exOperand2;
    logic [CB-1:0]  exAluCtrl;
    logic           exRegWrEn;
    logic [SB-1:0]  exRegToWrite;
    logic           scbErr;

    decode_execute_reg #(
        .registerSize (RS),
        .vecSize      (VS),
        .selectionBits(SB),
        .ctrlBits     (CB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .idValid     (idValid),
        .rSel1       (rSel1),
        .rSel2       (rSel2),
        .useOp1      (useOp1),
        .useOp2      (useOp2),
        .regWrEn     (regWrEn),
        .regToWrite  (regToWrite),
        .aluCtrl     (aluCtrl),
        .operand1    (operand1),
        .operand2    (operand2),
        .exReady     (exReady),
        .flush       (flush),
        .wbValid     (wbValid),
        .wbReg       (wbReg),
        .stall       (stall),
        .exValid     (exValid),
        .exOperand1  (exOperand1),
        .exOperand2  (exOperand2),
        .exAluCtrl   (exAluCtrl),
        .exRegWrEn   (exRegWrEn),
        .exRegToWrite(exRegToWrite),
        .scbErr      (scbErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id, rs1, rs2, u1, u2, we, rd, ctrl, seed, rdy, fl, wb, wbr;
        int e_stall, e_v, e_rd, e_ctrl, e_seed, e_wen, e_err;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [OPW-1:0] mk(input int seed);
        logic [OPW-1:0] r;
        r = '0;
        for (int i = 0; i < VS; i++) begin
            r[i*RS +: RS] = RS'(seed + i);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [OPW-1:0] act, input logic [OPW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input vec_t v);
        tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        idValid    = v.id[0];
        rSel1      = v.rs1[SB-1:0];
        rSel2      = v.rs2[SB-1:0];
        useOp1     = v.u1[0];
        useOp2     = v.u2[0];
        regWrEn    = v.we[0];
        regToWrite = v.rd[SB-1:0];
        aluCtrl    = v.ctrl[CB-1:0];
        operand1   = mk(v.seed);
        operand2   = mk(v.seed + 128);
        exReady    = v.rdy[0];
        flush      = v.fl[0];
        wbValid    = v.wb[0];
        wbReg      = v.wbr[SB-1:0];
    endtask

    initial begin
        //  id rs1 rs2 u1 u2 we rd ctrl  seed rdy fl wb wbr | stall v rd ctrl  seed wen err
        // RAW on r5, released the cycle after its retire
        add('{1, 2, 3, 1, 1, 1, 5, 'h11, 'h10, 1, 0, 0, 0,   0, 1, 5, 'h11, 'h10, 1, 0});
        add('{1, 5, 0, 1, 0, 0, 0, 'h22, 'h20, 1, 0, 0, 0,   1, 0, 5, 'h11, 'h10, 1, 0});
        add('{1, 5, 0, 1, 0, 0, 0, 'h22, 'h20, 1, 0, 1, 5,   1, 0, 5, 'h11, 'h10, 1, 0});
        add('{1, 5, 0, 1, 0, 0, 0, 'h22, 'h20, 1, 0, 0, 0,   0, 1, 0, 'h22, 'h20, 0, 0});
        // three back-to-back writers to r4, fourth blocked until a retire
        add('{1, 0, 0, 0, 0, 1, 4, 'h04, 'h40, 1, 0, 0, 0,   0, 1, 4, 'h04, 'h40, 1, 0});
        add('{1, 0, 0, 0, 0, 1, 4, 'h05, 'h41, 1, 0, 0, 0,   0, 1, 4, 'h05, 'h41, 1, 0});
        add('{1, 0, 0, 0, 0, 1, 4, 'h06, 'h42, 1, 0, 0, 0,   0, 1, 4, 'h06, 'h42, 1, 0});
        add('{1, 0, 0, 0, 0, 1, 4, 'h07, 'h43, 1, 0, 0, 0,   1, 0, 4, 'h06, 'h42, 1, 0});
        add('{1, 0, 0, 0, 0, 1, 4, 'h07, 'h43, 1, 0, 1, 4,   1, 0, 4, 'h06, 'h42, 1, 0});
        add('{1, 0, 0, 0, 0, 1, 4, 'h07, 'h43, 1, 0, 0, 0,   0, 1, 4, 'h07, 'h43, 1, 0});
        // backpressure for four cycles, then a no-bubble handover
        add('{1, 0, 0, 0, 0, 0, 1, 'h31, 'h31, 0, 0, 0, 0,   1, 1, 4, 'h07, 'h43, 1, 0});
        add('{1, 0, 0, 0, 0, 0, 1, 'h31, 'h31, 0, 0, 0, 0,   1, 1, 4, 'h07, 'h43, 1, 0});
        add('{1, 0, 0, 0, 0, 0, 1, 'h31, 'h31, 0, 0, 0, 0,   1, 1, 4, 'h07, 'h43, 1, 0});
        add('{1, 0, 0, 0, 0, 0, 1, 'h31, 'h31, 0, 0, 0, 0,   1, 1, 4, 'h07, 'h43, 1, 0});
        add('{1, 0, 0, 0, 0, 0, 1, 'h31, 'h31, 1, 0, 0, 0,   0, 1, 1, 'h31, 'h31, 0, 0});
        // flush of a held r6 writer undoes its count
        add('{1, 0, 0, 0, 0, 1, 6, 'h36, 'h66, 1, 0, 0, 0,   0, 1, 6, 'h36, 'h66, 1, 0});
        add('{1, 6, 0, 1, 0, 0, 2, 'h12, 'h12, 0, 1, 0, 0,   0, 0, 6, 'h36, 'h66, 1, 0});
        add('{1, 6, 0, 1, 0, 0, 2, 'h12, 'h12, 0, 0, 0, 0,   0, 1, 2, 'h12, 'h12, 0, 0});
        // flush together with exReady keeps the r3 write counted
        add('{1, 0, 0, 0, 0, 1, 3, 'h03, 'h03, 1, 0, 0, 0,   0, 1, 3, 'h03, 'h03, 1, 0});
        add('{0, 0, 0, 0, 0, 0, 0, 'h00, 'h00, 1, 1, 0, 0,   0, 0, 3, 'h03, 'h03, 1, 0});
        add('{1, 3, 0, 1, 0, 0, 0, 'h2A, 'h2A, 0, 0, 0, 0,   1, 0, 3, 'h03, 'h03, 1, 0});
        add('{1, 3, 0, 1, 0, 0, 0, 'h2A, 'h2A, 0, 0, 1, 3,   1, 0, 3, 'h03, 'h03, 1, 0});
        add('{1, 3, 0, 1, 0, 0, 0, 'h2A, 'h2A, 0, 0, 0, 0,   0, 1, 0, 'h2A, 'h2A, 0, 0});
        // accept and retire on r4 in the same cycle leaves the count at 2
        add('{0, 0, 0, 0, 0, 0, 0, 'h00, 'h00, 1, 0, 1, 4,   0, 0, 0, 'h2A, 'h2A, 0, 0});
        add('{1, 0, 0, 0, 0, 1, 4, 'h14, 'h14, 1, 0, 1, 4,   0, 1, 4, 'h14, 'h14, 1, 0});
        add('{1, 0, 0, 0, 0, 1, 4, 'h15, 'h15, 1, 0, 0, 0,   0, 1, 4, 'h15, 'h15, 1, 0});
        add('{1, 0, 0, 0, 0, 1, 4, 'h16, 'h16, 1, 0, 0, 0,   1, 0, 4, 'h15, 'h15, 1, 0});
        // second source port hazard, and an unused source is ignored
        add('{1, 0, 4, 0, 1, 0, 0, 'h28, 'h28, 1, 0, 0, 0,   1, 0, 4, 'h15, 'h15, 1, 0});
        add('{1, 0, 4, 0, 0, 0, 0, 'h28, 'h28, 1, 0, 0, 0,   0, 1, 0, 'h28, 'h28, 0, 0});
        // retire of an idle register: sticky error, counter stays 0
        add('{0, 0, 0, 0, 0, 0, 0, 'h00, 'h00, 1, 0, 1, 7,   0, 0, 0, 'h28, 'h28, 0, 1});
        add('{1, 0, 0, 0, 0, 1, 7, 'h37, 'h37, 1, 0, 0, 0,   0, 1, 7, 'h37, 'h37, 1, 1});

        // reset state
        drive('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_exValid", OPW'(exValid), OPW'(1'b0));
        chk("rst_exRegToWrite", OPW'(exRegToWrite), OPW'(3'd0));
        chk("rst_exAluCtrl", OPW'(exAluCtrl), OPW'(6'd0));
        chk("rst_exRegWrEn", OPW'(exRegWrEn), OPW'(1'b0));
        chk("rst_exOperand1", exOperand1, '0);
        chk("rst_exOperand2", exOperand2, '0);
        chk("rst_scbErr", OPW'(scbErr), OPW'(1'b0));
        chk("rst_stall_idle", OPW'(stall), OPW'(1'b0));
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), OPW'(stall), OPW'(tbl[i].e_stall[0]));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_exValid", i), OPW'(exValid), OPW'(tbl[i].e_v[0]));
            chk($sformatf("v%0d_exRegToWrite", i), OPW'(exRegToWrite), OPW'(tbl[i].e_rd[SB-1:0]));
            chk($sformatf("v%0d_exAluCtrl", i), OPW'(exAluCtrl), OPW'(tbl[i].e_ctrl[CB-1:0]));
            chk($sformatf("v%0d_exRegWrEn", i), OPW'(exRegWrEn), OPW'(tbl[i].e_wen[0]));
            chk($sformatf("v%0d_exOperand1", i), exOperand1, mk(tbl[i].e_seed));
            chk($sformatf("v%0d_exOperand2", i), exOperand2, mk(tbl[i].e_seed + 128));
            chk($sformatf("v%0d_scbErr", i), OPW'(scbErr), OPW'(tbl[i].e_err[0]));
        end

        // reset mid-operation beats flush, a writer and an erroneous retire;
        // r4 had three writes in flight beforehand
        drive('{1, 0, 0, 0, 0, 1, 4, 'h3F, 'h55, 0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0});
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_exValid", OPW'(exValid), OPW'(1'b0));
        chk("mrst_exRegToWrite", OPW'(exRegToWrite), OPW'(3'd0));
        chk("mrst_exAluCtrl", OPW'(exAluCtrl), OPW'(6'd0));
        chk("mrst_exOperand1", exOperand1, '0);
        chk("mrst_scbErr", OPW'(scbErr), OPW'(1'b0));
        reset = 1'b0;
        drive('{1, 0, 0, 0, 0, 1, 4, 'h3F, 'h99, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        @(negedge clk);
        chk("mrst_r4_cleared_stall", OPW'(stall), OPW'(1'b0));
        @(posedge clk);
        #1;
        chk("mrst_acc_exValid", OPW'(exValid), OPW'(1'b1));
        chk("mrst_acc_exRegToWrite", OPW'(exRegToWrite), OPW'(3'd4));
        chk("mrst_acc_exAluCtrl", OPW'(exAluCtrl), OPW'(6'h3F));
        chk("mrst_acc_exOperand1", exOperand1, mk('h99));
        drive('{1, 0, 0, 0, 0, 0, 1, 'h01, 'h01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        @(negedge clk);
        chk("mrst_backpressure_stall", OPW'(stall), OPW'(1'b1));
        idValid = 1'b0;
        #1;
        chk("mrst_idle_stall", OPW'(stall), OPW'(1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_execute_reg.md
# decode_execute_reg

Decode-to-execute pipeline register with a per-register write scoreboard for the SIMD processor. It captures the operands produced by the register-file read in decode, together with the control fields, and presents them to the execute stage through a valid/ready handshake. It tracks in-flight writes to every architectural register and stalls decode on read-after-write hazards or counter saturation. It also squashes the execute-side slot on a flush.

## Interface
- registerSize, 8, bits per vector lane / scalar
- vecSize, 16, lanes per vector operand
- selectionBits, 3, register identifier width; 2^selectionBits registers are tracked
- ctrlBits, 6, opaque execute control field width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- idValid  in  1  decode presents an instruction
- rSel1, rSel2  in  selectionBits  source register identifiers
- useOp1, useOp2  in  1  instruction actually reads rSel1 / rSel2
- regWrEn  in  1  instruction writes a register (scalar or vector)
- regToWrite  in  selectionBits  destination identifier
- aluCtrl  in  ctrlBits  execute control
- operand1, operand2  in  vecSize×registerSize  register-file read data
- exReady  in  1  execute accepts the current slot this cycle
- flush  in  1  squash decode and execute-side slot
- wbValid  in  1  writeback retires a register write this cycle
- wbReg  in  selectionBits  register retired
- stall  out  1  decode must hold its instruction
- exValid  out  1  slot holds a valid instruction
- exOperand1, exOperand2  out  vecSize×registerSize  latched operands
- exAluCtrl  out  ctrlBits; exRegWrEn  out  1; exRegToWrite  out  selectionBits
- scbErr  out  1  sticky: retire seen for a register with zero pending writes

## Operation
- Scoreboard: one 2-bit counter pending[r] per register, holding the number of accepted-but-unretired writes. The maximum is 3.
- hazard = idValid && ((useOp1 && pending[rSel1]!=0) || (useOp2 && pending[rSel2]!=0) || (regWrEn && pending[regToWrite]==3)).
- accept = idValid && !hazard && !flush && (!exValid || exReady).
- stall = idValid && !accept && !flush. This output is combinational. On a flush, the decode instruction is discarded, not stalled.
- Slot update, in priority order:
  - flush: exValid←0.
  - accept: load all ex* fields from the inputs; exValid←1.
  - exReady: exValid←0.
  - Otherwise hold all ex* fields.
- Counter update per register r, computed from three terms and applied together:
  - inc = accept && regWrEn && regToWrite==r.
  - dec_wb = wbValid && wbReg==r && pending[r]!=0.
  - dec_fl = flush && exValid && !exReady && exRegWrEn && exRegToWrite==r. This undoes the increment for the squashed slot. If exReady is also 1, the slot has already moved to execute and is not undone.
  - New value = pending + inc − dec_wb − dec_fl, clamped to 0..3.
- wbValid with pending[wbReg]==0: the counter is unchanged and scbErr←1. scbErr clears only on reset.
- There is no forwarding. The source check uses the registered counter, so a retire in cycle N releases a dependent decode in cycle N+1. By then the register file holds the new data.

## Timing
- Reset: exValid=0, all ex* data/control fields=0, every pending=0, scbErr=0. stall=0 whenever idValid=0.
- Latency: an instruction accepted at edge N appears on ex* after edge N, and stays there until the edge where exReady=1 or flush=1.
- Backpressure: with exValid=1 and exReady=0, accept is 0 and ex* outputs are stable.
- Full throughput: exValid=1, exReady=1 and a new accept in the same cycle gives back-to-back slots with no bubble.
- Accept and retire on the same register in the same cycle: the counter is unchanged.
- Reset mid-operation overrides flush and all other inputs. The scoreboard clears, so writes in flight past writeback are forgotten.

## Test plan
- Reset, then idValid=1, rSel1=2, rSel2=3, useOp1=useOp2=1, regWrEn=1, regToWrite=5, exReady=1 → stall=0; next cycle exValid=1, exRegToWrite=5, pending[5]=1, exOperand1 equals operand1 captured at the edge.
- Write r5 is in flight; decode reads r5 (useOp1=1, rSel1=5) → stall=1. Pulse wbValid with wbReg=5 in cycle N → stall stays 1 in cycle N, is 0 in cycle N+1, and the instruction is accepted.
- Three accepted writes to r4 with no retire → pending[4]=3; a fourth writer to r4 → stall=1 until one retire.
- exValid=1, exReady=0 for 4 cycles → ex* outputs constant and stall=1 for a waiting idValid; exReady=1 with a valid decode → exValid stays 1, new fields loaded, no bubble.
- Slot holds a write to r6 (pending[6]=1), flush=1 with exReady=0 → exValid=0, pending[6]=0, stall=0 even though idValid=1.
- wbValid with wbReg=7 and pending[7]=0 → scbErr=1, pending[7] stays 0; reset → scbErr=0.
